fmcrop: RTL and testbench



---
 rtl/fmcrop_if.sv | 12 +
 rtl/fmcrop.sv | 157 +++++++++++++++
 tb/tb_fmcrop.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmcrop_if.sv
// AXI-Stream style handshake bundle for the crop core.
// The master drives valid/data and the slave drives ready.
interface fmcrop_if #(
   parameter int unsigned STREAM_BITS = 16
) ();
   logic                   tvalid;
   logic                   tready;
   logic [STREAM_BITS-1:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fmcrop.sv
// Feature-map crop: forwards only the beats of pixels inside a programmable window.
// Geometry writes land in shadow registers and take effect at the next frame start.
module fmcrop #(
   parameter int unsigned XCOUNTER_BITS = 8,
   parameter int unsigned YCOUNTER_BITS = 8,
   parameter int unsigned NUM_CHANNELS  = 4,
   parameter int unsigned SIMD          = 2,
   parameter int unsigned ELEM_BITS     = 8,
   parameter int unsigned INIT_XON      = 1,
   parameter int unsigned INIT_XOFF     = 3,
   parameter int unsigned INIT_XEND     = 3,
   parameter int unsigned INIT_YON      = 1,
   parameter int unsigned INIT_YOFF     = 3,
   parameter int unsigned INIT_YEND     = 3
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   fmcrop_if.slave     s_axis,
   fmcrop_if.master    m_axis
);
   localparam int unsigned STREAM_BITS = 8 * (1 + (SIMD * ELEM_BITS - 1) / 8);
   localparam int unsigned FOLD        = NUM_CHANNELS / SIMD;
   localparam int unsigned CF_BITS     = (FOLD > 1) ? $clog2(FOLD) : 1;

   typedef logic [XCOUNTER_BITS-1:0] x_t;
   typedef logic [YCOUNTER_BITS-1:0] y_t;
   typedef logic [CF_BITS-1:0]       cf_t;

   localparam cf_t CF_LAST = cf_t'(FOLD - 1);

   cf_t r_cf;
   x_t  r_x;
   y_t  r_y;
   x_t  r_xon, r_xoff, r_xend, r_s_xon, r_s_xoff, r_s_xend;
   y_t  r_yon, r_yoff, r_yend, r_s_yon, r_s_yoff, r_s_yend;

   logic [STREAM_BITS-1:0] r_mem [2];
   logic                   r_wr;
   logic                   r_rd;
   logic [1:0]             r_cnt;
   logic                   r_valid;
   logic                   r_s_ready;

   logic       w_start;
   x_t         w_xon, w_xoff, w_xend;
   y_t         w_yon, w_yoff, w_yend;
   logic       w_keep;
   logic       w_acc;
   logic       w_push;
   logic       w_pop;
   logic [1:0] w_cnt_nxt;
   logic       w_unused;

   // At frame start the shadow set is the one in force, even for the very first beat.
   assign w_start = (r_cf == '0) && (r_x == '0) && (r_y == '0);
   assign w_xon   = w_start ? r_s_xon  : r_xon;
   assign w_xoff  = w_start ? r_s_xoff : r_xoff;
   assign w_xend  = w_start ? r_s_xend : r_xend;
   assign w_yon   = w_start ? r_s_yon  : r_yon;
   assign w_yoff  = w_start ? r_s_yoff : r_yoff;
   assign w_yend  = w_start ? r_s_yend : r_yend;

   assign w_keep    = (r_x >= w_xon) && (r_x < w_xoff) && (r_y >= w_yon) && (r_y < w_yoff);
   assign w_acc     = s_axis.tvalid & r_s_ready;
   assign w_push    = w_acc & w_keep;
   assign w_pop     = r_valid & m_axis.tready;
   assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
   assign w_unused  = ^{wa[1:0], wd};

   assign s_axis.tready = r_s_ready;
   assign m_axis.tvalid = r_valid;
   assign m_axis.tdata  = r_mem[r_rd];

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_s_xon  <= x_t'(INIT_XON);
         r_s_xoff <= x_t'(INIT_XOFF);
         r_s_xend <= x_t'(INIT_XEND);
         r_s_yon  <= y_t'(INIT_YON);
         r_s_yoff <= y_t'(INIT_YOFF);
         r_s_yend <= y_t'(INIT_YEND);
         r_xon    <= x_t'(INIT_XON);
         r_xoff   <= x_t'(INIT_XOFF);
         r_xend   <= x_t'(INIT_XEND);
         r_yon    <= y_t'(INIT_YON);
         r_yoff   <= y_t'(INIT_YOFF);
         r_yend   <= y_t'(INIT_YEND);
      end else begin
         if (we) begin
            case (wa[4:2])
               3'd0:    r_s_xon  <= wd[XCOUNTER_BITS-1:0];
               3'd1:    r_s_xoff <= wd[XCOUNTER_BITS-1:0];
               3'd2:    r_s_xend <= wd[XCOUNTER_BITS-1:0];
               3'd3:    r_s_yon  <= wd[YCOUNTER_BITS-1:0];
               3'd4:    r_s_yoff <= wd[YCOUNTER_BITS-1:0];
               3'd5:    r_s_yend <= wd[YCOUNTER_BITS-1:0];
               default: ;
            endcase
         end
         if (w_start) begin
            r_xon  <= r_s_xon;
            r_xoff <= r_s_xoff;
            r_xend <= r_s_xend;
            r_yon  <= r_s_yon;
            r_yoff <= r_s_yoff;
            r_yend <= r_s_yend;
         end
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_cf <= '0;
         r_x  <= '0;
         r_y  <= '0;
      end else if (w_acc) begin
         if (r_cf == CF_LAST) begin
            r_cf <= '0;
            if (r_x == w_xend) begin
               r_x <= '0;
               r_y <= (r_y == w_yend) ? '0 : r_y + y_t'(1);
            end else begin
               r_x <= r_x + x_t'(1);
            end
         end else begin
            r_cf <= r_cf + cf_t'(1);
         end
      end
   end

   // Two-entry output buffer; ready looks at the occupancy left after this cycle.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_mem[0]  <= '0;
         r_mem[1]  <= '0;
         r_wr      <= 1'b0;
         r_rd      <= 1'b0;
         r_cnt     <= 2'd0;
         r_valid   <= 1'b0;
         r_s_ready <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= s_axis.tdata;
            r_wr        <= ~r_wr;
         end
         if (w_pop) begin
            r_rd <= ~r_rd;
         end
         r_cnt     <= w_cnt_nxt;
         r_valid   <= (w_cnt_nxt != 2'd0);
         r_s_ready <= ~w_cnt_nxt[1];
      end
   end
endmodule

// File: tb/tb_fmcrop.sv
// Randomized bench for fmcrop against a frame-level window model and output scoreboard.
// Each frame's expected kept beats are derived from the geometry latched at frame start.
module tb_fmcrop;
   localparam int P     = 2;
   localparam int FRAME = 32;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        we     = 1'b0;
   logic [4:0]  wa     = '0;
   logic [31:0] wd     = '0;

   fmcrop_if #(.STREAM_BITS(16)) s_if ();
   fmcrop_if #(.STREAM_BITS(16)) m_if ();

   fmcrop dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .we     (we),
      .wa     (wa),
      .wd     (wd),
      .s_axis (s_if),
      .m_axis (m_if)
   );

   always #5 ap_clk = ~ap_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Geometry model: XON XOFF XEND YON YOFF YEND
   int init_g[6] = '{1, 3, 3, 1, 3, 3};
   int sh[6];
   int act[6];

   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   bit          cur_keep  = 0;
   bit          rnd_ready = 0;
   int          pending   = 0;
   int          out_cnt   = 0;
   int          vcount    = 0;

   function automatic bit model_keep(input int i);
      int pix, x, y;
      pix = i / P;
      x   = pix % (act[2] + 1);
      y   = pix / (act[2] + 1);
      return (x >= act[0]) && (x < act[1]) && (y >= act[3]) && (y < act[4]);
   endfunction

   // Scoreboard and handshake monitor, sampled mid-cycle.
   initial begin
      bit   prev_stall = 0;
      logic [15:0] prev_data = '0;
      bit   in_b, out_b;
      forever begin
         @(negedge ap_clk);
         if (ap_rst) begin
            prev_stall = 0;
            pending    = 0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 32'(m_if.tvalid), 1);
               check("hold_data", 32'(m_if.tdata), 32'(prev_data));
            end
            in_b  = s_if.tvalid && s_if.tready && cur_keep;
            out_b = m_if.tvalid && m_if.tready;
            if (m_if.tvalid) vcount++;
            if (out_b) begin
               out_cnt++;
               got_q.push_back(m_if.tdata);
               if (exp_q.size() == 0) check("spurious_out", 32'(m_if.tvalid), 0);
               else check("out_data", 32'(m_if.tdata), 32'(exp_q.pop_front()));
            end
            pending = pending + int'(in_b) - int'(out_b);
            if (in_b) check("occupancy_le2", 32'(pending <= 2), 1);
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
         end
      end
   end

   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge ap_clk);
         #1;
         m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic wr(input logic [4:0] addr, input int data);
      we = 1'b1;
      wa = addr;
      wd = 32'(data);
      @(posedge ap_clk);
      #1;
      we = 1'b0;
      if (addr[4:2] < 3'd6) sh[addr[4:2]] = data & 8'hff;
   endtask

   task automatic start_frame(input int base);
      act = sh;
      got_q.delete();
      out_cnt = 0;
      vcount  = 0;
      for (int i = 0; i < FRAME; i++) if (model_keep(i)) exp_q.push_back(16'(base + i));
   endtask

   task automatic send(input int base, input int from, input int upto, input int gap_pct,
                       output int cycles, output int not_ready);
      cycles    = 0;
      not_ready = 0;
      for (int i = from; i < upto; i++) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            s_if.tvalid = 1'b0;
            cur_keep    = 0;
            repeat ($urandom_range(1, 3)) begin
               @(posedge ap_clk);
               #1;
            end
         end
         s_if.tvalid = 1'b1;
         s_if.tdata  = 16'(base + i);
         cur_keep    = model_keep(i);
         forever begin
            @(negedge ap_clk);
            cycles++;
            if (s_if.tready) break;
            not_ready++;
            if (not_ready > 1000) begin
               check("s_ready_timeout", 32'(s_if.tready), 1);
               break;
            end
         end
         @(posedge ap_clk);
         #1;
      end
      s_if.tvalid = 1'b0;
      cur_keep    = 0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 0 && pending == 0) break;
         @(posedge ap_clk);
         #1;
      end
      check("drain_left", 32'(exp_q.size()), 0);
   endtask

   task automatic check_init_seq(input string tag, input int base);
      int lit[8] = '{10, 11, 12, 13, 18, 19, 20, 21};
      check({tag, "_count"}, 32'(got_q.size()), 8);
      for (int k = 0; k < 8 && k < got_q.size(); k++)
         check({tag, "_seq"}, 32'(got_q[k]), 32'(16'(base + lit[k])));
   endtask

   initial begin
      int cyc, nr, base;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      sh  = init_g;
      act = init_g;

      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      check("rst_m_valid", 32'(m_if.tvalid), 0);
      check("rst_m_data", 32'(m_if.tdata), 0);
      check("rst_s_ready", 32'(s_if.tready), 0);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("s_ready_after_rst", 32'(s_if.tready), 1);
      @(posedge ap_clk);
      #1;

      // Default window, free-flowing output
      start_frame(0);
      send(0, 0, FRAME, 0, cyc, nr);
      check("s1_ready_stall", 32'(nr), 0);
      drain();
      check_init_seq("s1", 0);

      // Random output backpressure
      rnd_ready = 1;
      base = int'($urandom_range(0, 16'hff00));
      start_frame(base);
      send(base, 0, FRAME, 0, cyc, nr);
      drain();
      rnd_ready = 0;
      check_init_seq("s2", base);

      // Mid-frame window change affects only the next frame
      start_frame(16'h100);
      send(16'h100, 0, 16, 0, cyc, nr);
      wr(5'h00, 0);
      wr(5'h04, 4);
      wr(5'h0c, 0);
      wr(5'h10, 4);
      send(16'h100, 16, FRAME, 0, cyc, nr);
      drain();
      check("s3_cur_count", 32'(out_cnt), 8);
      start_frame(16'h200);
      send(16'h200, 0, FRAME, 0, cyc, nr);
      drain();
      check("s3_next_count", 32'(out_cnt), 32);
      for (int k = 0; k < 32 && k < got_q.size(); k++)
         check("s3_next_seq", 32'(got_q[k]), 32'(16'h200 + k));

      // Empty window: full-rate consumption, no output
      wr(5'h04, 2);
      wr(5'h00, 2);
      start_frame(16'h300);
      send(16'h300, 0, FRAME, 0, cyc, nr);
      drain();
      check("s4_cycles", 32'(cyc), 32);
      check("s4_valid_cycles", 32'(vcount), 0);

      // Reset mid-frame with an output pending
      wr(5'h00, 1);
      wr(5'h04, 3);
      wr(5'h0c, 1);
      wr(5'h10, 3);
      start_frame(16'h400);
      send(16'h400, 0, 14, 0, cyc, nr);
      ap_rst = 1'b1;
      #1;
      check("s5_valid_on_rst", 32'(m_if.tvalid), 0);
      exp_q.delete();
      sh = init_g;
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      @(posedge ap_clk);
      #1;
      start_frame(16'h500);
      send(16'h500, 0, FRAME, 0, cyc, nr);
      drain();
      check_init_seq("s5", 16'h500);

      // Unmapped register code is ignored
      wr(5'h18, 0);
      start_frame(0);
      send(0, 0, FRAME, 0, cyc, nr);
      drain();
      check_init_seq("s6", 0);

      // Random windows, gaps and backpressure
      rnd_ready = 1;
      for (int f = 0; f < 6; f++) begin
         wr(5'h00, int'($urandom_range(0, 4)));
         wr(5'h04, int'($urandom_range(0, 4)));
         wr(5'h0c, int'($urandom_range(0, 4)));
         wr(5'h10, int'($urandom_range(0, 4)));
         base = int'($urandom_range(0, 16'hff00));
         start_frame(base);
         send(base, 0, FRAME, 30, cyc, nr);
         drain();
      end
      rnd_ready = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
